// File: rtl/seq_addsub_multiplier_if.sv
// Handshake and operand/product bundle for the sequential add/sub multiplier.
interface seq_addsub_multiplier_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 Start;
  logic                 Signed_mode;
  logic [WIDTH-1:0]     Multiplicand;
  logic [WIDTH-1:0]     Multiplier;
  logic                 Busy;
  logic                 Done;
  logic [2*WIDTH-1:0]   Product;

  modport master (
    output Start, Signed_mode, Multiplicand, Multiplier,
    input  Busy, Done, Product
  );

  modport slave (
    input  Start, Signed_mode, Multiplicand, Multiplier,
    output Busy, Done, Product
  );
endinterface

// File: rtl/seq_addsub_multiplier.sv
// Sequential shift-add multiplier, signed or unsigned, one partial product per
// clock through a WIDTH+1-bit add/subtract stage.
module seq_addsub_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input logic                   Clk,
  input logic                   Reset_n,
  seq_addsub_multiplier_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic             x_q, x_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             sgn_q, sgn_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [PW-1:0]    product_q, product_d;

  logic             last_step_c;
  logic             sub_c;
  logic [WIDTH:0]   ext_a_c, ext_m_c, addend_c, sum_c;

  // Add/subtract stage: the final signed step subtracts M to weight Q's sign bit negatively.
  always_comb begin
    last_step_c = (cnt_q == CW'(WIDTH - 1));
    sub_c       = last_step_c & sgn_q;
    ext_a_c     = sgn_q ? {x_q, a_q} : {1'b0, a_q};
    ext_m_c     = sgn_q ? {m_q[WIDTH-1], m_q} : {1'b0, m_q};
    addend_c    = '0;
    if (b_q[0]) begin
      addend_c = sub_c ? ~ext_m_c : ext_m_c;
    end
    sum_c = ext_a_c + addend_c + {{WIDTH{1'b0}}, b_q[0] & sub_c};
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    a_d       = a_q;
    b_d       = b_q;
    m_d       = m_q;
    sgn_d     = sgn_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;

    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          m_d     = bus.Multiplicand;
          b_d     = bus.Multiplier;
          sgn_d   = bus.Signed_mode;
          a_d     = '0;
          x_d     = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // Right shift of {S, B}; in unsigned mode the carry lands in A's MSB and X stays 0.
        x_d   = sgn_q ? sum_c[WIDTH] : 1'b0;
        a_d   = sum_c[WIDTH:1];
        b_d   = {sum_c[0], b_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (last_step_c) begin
          product_d = {sum_c[WIDTH:1], sum_c[0], b_q[WIDTH-1:1]};
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      x_q       <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      m_q       <= '0;
      sgn_q     <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      a_q       <= a_d;
      b_q       <= b_d;
      m_q       <= m_d;
      sgn_q     <= sgn_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign bus.Product = product_q;

endmodule

// File: tb/tb_seq_addsub_multiplier.sv
// Randomized and directed bench for seq_addsub_multiplier at WIDTH=8 and WIDTH=4,
// checked against an integer-arithmetic product model.
module tb_seq_addsub_multiplier;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;

  logic [15:0] prev8;
  logic [15:0] prev4;

  seq_addsub_multiplier_if #(.WIDTH(8)) bus8 ();
  seq_addsub_multiplier_if #(.WIDTH(4)) bus4 ();

  seq_addsub_multiplier #(.WIDTH(8)) dut8 (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus8.slave)
  );

  seq_addsub_multiplier #(.WIDTH(4)) dut4 (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference product of two w-bit operands interpreted per mode, masked to 2w bits.
  function automatic logic [15:0] ref_prod(input int w, input logic [7:0] m, input logic [7:0] q,
                                           input bit sgn);
    longint lim, mv, qv, p;
    lim = longint'(1) << w;
    mv  = longint'(m) & (lim - 1);
    qv  = longint'(q) & (lim - 1);
    if (sgn) begin
      if (mv >= lim / 2) mv = mv - lim;
      if (qv >= lim / 2) qv = qv - lim;
    end
    p = mv * qv;
    return 16'(p & ((lim * lim) - 1));
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 8) ? bus8.Busy : bus4.Busy;
  endfunction

  function automatic logic get_done(input int w);
    return (w == 8) ? bus8.Done : bus4.Done;
  endfunction

  function automatic logic [15:0] get_prod(input int w);
    return (w == 8) ? bus8.Product : {8'h00, bus4.Product};
  endfunction

  task automatic drive(input int w, input logic start, input logic [7:0] m, input logic [7:0] q,
                       input bit sgn);
    if (w == 8) begin
      bus8.Start = start; bus8.Multiplicand = m; bus8.Multiplier = q; bus8.Signed_mode = sgn;
    end else begin
      bus4.Start = start; bus4.Multiplicand = m[3:0]; bus4.Multiplier = q[3:0];
      bus4.Signed_mode = sgn;
    end
  endtask

  // One full operation: start pulse, scrambled inputs after capture, bounded wait for Done.
  task automatic run_op(input int w, input logic [7:0] m, input logic [7:0] q, input bit sgn,
                        output logic [15:0] got);
    logic [15:0] exp;
    logic [15:0] prev;
    int          n;
    bit          seen;
    exp  = ref_prod(w, m, q, sgn);
    prev = (w == 8) ? prev8 : prev4;
    @(negedge clk);
    drive(w, 1'b1, m, q, sgn);
    @(negedge clk);
    drive(w, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    check_eq("busy_after_start", 64'(get_busy(w)), 64'd1);
    n    = 0;
    seen = 0;
    while (n < 3 * w && !seen) begin
      @(negedge clk);
      n++;
      if (n == w / 2) check_eq("product_held_mid_run", 64'(get_prod(w)), 64'(prev));
      if (get_done(w)) seen = 1;
    end
    check_eq("done_latency", 64'(n), 64'(w));
    check_eq("busy_at_done", 64'(get_busy(w)), 64'd0);
    got = get_prod(w);
    check_eq("product", 64'(got), 64'(exp));
    @(negedge clk);
    check_eq("done_one_cycle", 64'(get_done(w)), 64'd0);
    if (w == 8) prev8 = exp; else prev4 = exp;
  endtask

  initial begin
    logic [15:0] got;
    logic [7:0]  ma, qa, mb, qb;
    int          t, t1, t2, dones;

    n_checks = 0;
    n_fail   = 0;
    prev8    = '0;
    prev4    = '0;
    drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(4, 1'b0, 8'h00, 8'h00, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_busy8", 64'(bus8.Busy), 64'd0);
    check_eq("rst_done8", 64'(bus8.Done), 64'd0);
    check_eq("rst_prod8", 64'(bus8.Product), 64'd0);
    check_eq("rst_prod4", 64'(bus4.Product), 64'd0);

    // Directed cases
    run_op(8, 8'hF9, 8'h05, 1'b1, got); check_eq("s_m7x5", 64'(got), 64'hFFDD);
    run_op(8, 8'h80, 8'h80, 1'b1, got); check_eq("s_min_sq", 64'(got), 64'h4000);
    run_op(8, 8'hFF, 8'hFF, 1'b0, got); check_eq("u_ffxff", 64'(got), 64'hFE01);
    run_op(8, 8'hFF, 8'hFF, 1'b1, got); check_eq("s_ffxff", 64'(got), 64'h0001);
    run_op(8, 8'h00, 8'h5A, 1'b1, got); check_eq("s_zero", 64'(got), 64'h0000);
    run_op(4, 8'h08, 8'h07, 1'b1, got); check_eq("w4_s_m8x7", 64'(got), 64'h00C8);
    run_op(4, 8'h0F, 8'h00, 1'b0, got); check_eq("w4_u_fx0", 64'(got), 64'h0000);
    run_op(4, 8'h08, 8'h08, 1'b1, got); check_eq("w4_s_min_sq", 64'(got), 64'h0040);

    // Start held high with operands changing during RUN
    ma = 8'h9C; qa = 8'h37; mb = 8'h21; qb = 8'hE5;
    @(negedge clk);
    drive(8, 1'b1, ma, qa, 1'b1);
    @(negedge clk);
    drive(8, 1'b1, mb, qb, 1'b0);
    t = 0; t1 = 0; t2 = 0; dones = 0;
    while (t < 40 && dones < 2) begin
      @(negedge clk);
      t++;
      if (bus8.Done) begin
        dones++;
        if (dones == 1) begin
          t1 = t;
          check_eq("hold_first_prod", 64'(bus8.Product), 64'(ref_prod(8, ma, qa, 1'b1)));
        end else begin
          t2 = t;
          check_eq("hold_second_prod", 64'(bus8.Product), 64'(ref_prod(8, mb, qb, 1'b0)));
        end
      end
    end
    drive(8, 1'b0, mb, qb, 1'b0);
    check_eq("hold_done_count", 64'(dones), 64'd2);
    check_eq("hold_first_latency", 64'(t1), 64'd8);
    check_eq("hold_done_spacing", 64'(t2 - t1), 64'd10);
    repeat (2) @(negedge clk);
    check_eq("hold_no_restart", 64'(bus8.Busy), 64'd0);
    prev8 = ref_prod(8, mb, qb, 1'b0);

    // Reset in the middle of 0x12*0x34
    @(negedge clk);
    drive(8, 1'b1, 8'h12, 8'h34, 1'b0);
    @(negedge clk);
    drive(8, 1'b0, 8'h12, 8'h34, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", 64'(bus8.Busy), 64'd0);
    check_eq("midrst_prod", 64'(bus8.Product), 64'd0);
    check_eq("midrst_done", 64'(bus8.Done), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus8.Done) dones++;
    end
    check_eq("midrst_no_done", 64'(dones), 64'd0);
    prev8 = '0;
    prev4 = '0;
    run_op(8, 8'h12, 8'h34, 1'b0, got); check_eq("after_rst_12x34", 64'(got), 64'h03A8);

    // Randomized operations on both widths
    for (int i = 0; i < 40; i++) begin
      run_op(8, 8'($urandom), 8'($urandom), 1'($urandom), got);
    end
    for (int i = 0; i < 20; i++) begin
      run_op(4, 8'($urandom), 8'($urandom), 1'($urandom), got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
